lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of a byte-addressed data memory with a one-cycle registered read.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [1:0]            mem_wbyte,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int unsigned SEXT_B = XLEN - 8;
  localparam int unsigned SEXT_H = XLEN - 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_LDW  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]            mem_wbyte_q, mem_wbyte_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  mem_ren_q, mem_ren_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic accept_c;
  logic width_ok_c;
  logic misalign_c;
  logic bad_c;

  function automatic logic [1:0] wbyte_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  return {{SEXT_B{d[7]}}, d[7:0]};
      3'b001:  return {{SEXT_H{d[15]}}, d[15:0]};
      3'b100:  return {{SEXT_B{1'b0}}, d[7:0]};
      3'b101:  return {{SEXT_H{1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign accept_c = req_valid && (state_q == S_IDLE);

  // Legality is decided on the live request, at the accept edge.
  always_comb begin
    width_ok_c = 1'b0;
    misalign_c = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: width_ok_c = 1'b1;
      3'b100, 3'b101:         width_ok_c = !req_we;
      default:                width_ok_c = 1'b0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_funct3[1:0] == 2'b01) misalign_c = req_addr[0];
    if (req_funct3[1:0] == 2'b10) misalign_c = (req_addr[1:0] != 2'b00);
`endif
    bad_c = !width_ok_c || misalign_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bad_c)       state_d = S_RESP;
          else if (req_we) state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_WR:    state_d = S_RESP;
      S_RD:    state_d = S_LDW;
      S_LDW:   state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes line up with the state they belong to.
  always_comb begin
    f3_d         = f3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wbyte_d  = mem_wbyte_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_wen_d    = (state_d == S_WR);
    mem_ren_d    = (state_d == S_RD);
    resp_valid_d = (state_d == S_RESP);
    if (accept_c) begin
      f3_d         = req_funct3;
      mem_addr_d   = req_addr;
      resp_err_d   = bad_c;
      resp_rdata_d = '0;
      if (req_we && !bad_c) begin
        mem_wdata_d = req_wdata;
        mem_wbyte_d = wbyte_of(req_funct3);
      end
    end
    if (state_q == S_LDW) resp_rdata_d = load_ext(f3_q, mem_rdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q         <= 3'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wbyte_q  <= 2'b00;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      f3_q         <= f3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wbyte_q  <= mem_wbyte_d;
      mem_wen_q    <= mem_wen_d;
      mem_ren_q    <= mem_ren_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Ready is low for the whole time reset is held.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wen    = mem_wen_q;
  assign mem_ren    = mem_ren_q;
  assign mem_wbyte  = mem_wbyte_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, reset-abort sequence and randomized traffic
// checked against a transaction-level memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_ren;
  logic [1:0]  mem_wbyte;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem     [4096] = '{default: 8'h00};
  logic [7:0] ref_mem [4096] = '{default: 8'h00};

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [1:0]  exp_wb;
  } vec_t;

  vec_t tbl[15];

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_wbyte(mem_wbyte), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (i < ((mem_wbyte == 2'b00) ? 1 : (mem_wbyte == 2'b01) ? 2 : 4))
          mem[12'(mem_addr + 32'(i))] <= 8'(mem_wdata >> (8 * i));
      end
    end
    if (mem_ren)
      mem_rdata <= {mem[12'(mem_addr + 32'd3)], mem[12'(mem_addr + 32'd2)],
                    mem[12'(mem_addr + 32'd1)], mem[12'(mem_addr)]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit model_legal(input bit we, input int f3, input logic [31:0] addr);
    if (we && f3 > 2) return 1'b0;
    if (!we && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((addr % (32'd1 << (f3 % 4))) != 0) return 1'b0;
`else
    if (addr === 32'hx) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] addr);
    int b0, b1, b2, b3, v;
    b0 = int'(ref_mem[12'(addr)]);
    b1 = int'(ref_mem[12'(addr + 32'd1)]);
    b2 = int'(ref_mem[12'(addr + 32'd2)]);
    b3 = int'(ref_mem[12'(addr + 32'd3)]);
    case (f3)
      0: begin v = b0;            return (v >= 128)   ? 32'(v - 256)   : 32'(v); end
      1: begin v = b0 + 256 * b1; return (v >= 32768) ? 32'(v - 65536) : 32'(v); end
      4: return 32'(b0);
      5: return 32'(b0 + 256 * b1);
      default: return 32'(b0) | (32'(b1) << 8) | (32'(b2) << 16) | (32'(b3) << 24);
    endcase
  endfunction

  task automatic model_store(input int f3, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[12'(addr + 32'(i))] = 8'(wdata >> (8 * i));
  endtask

  task automatic scramble_req();
    req_valid  = 1'b1;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Drives one transaction from a negedge; returns at the negedge after the response handshake.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nwen, output int nren, output logic [1:0] wb);
    lat = 0; nwen = 0; nren = 0; wb = 2'b00; rdata = '0; err = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_wen) begin
        nwen++;
        wb = mem_wbyte;
        chk({tag, " wen_addr"}, mem_addr, addr);
        chk({tag, " wen_wdata"}, mem_wdata, wdata);
      end
      if (mem_ren) begin
        nren++;
        chk({tag, " ren_addr"}, mem_addr, addr);
      end
      if (mem_wen && mem_ren) chk({tag, " wen_ren_overlap"}, 32'd1, 32'd0);
      chk({tag, " req_ready_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) begin
        lat = k;
        break;
      end
      scramble_req();
    end
    if (lat == 0) begin
      chk({tag, " resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    rdata = resp_rdata;
    err   = resp_err;
    for (int h = 0; h < hold; h++) begin
      scramble_req();
      @(negedge clk);
      chk({tag, " hold_rdata"}, resp_rdata, rdata);
      chk({tag, " hold_flags"}, {29'd0, resp_valid, resp_err, req_ready}, {29'd0, 1'b1, err, 1'b0});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk({tag, " post_resp_flags"}, {30'd0, resp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  wb;
    int          lat, nwen, nren;
    run_txn(tag, v.we, v.f3, v.addr, v.wdata, v.hold, rdata, err, lat, nwen, nren, wb);
    chk({tag, " err"}, 32'(err), 32'(v.exp_err));
    chk({tag, " rdata"}, rdata, v.exp_rdata);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " wen_pulses"}, 32'(nwen), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    chk({tag, " ren_pulses"}, 32'(nren), (!v.we && !v.exp_err) ? 32'd1 : 32'd0);
    if (v.we && !v.exp_err) chk({tag, " wbyte"}, 32'(wb), 32'(v.exp_wb));
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_flags", {26'd0, resp_valid, resp_err, mem_wen, mem_ren, mem_wbyte},  32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 32'd1);

    tbl[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0,        1'b0, 2, 2'b11};
    tbl[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF, 1'b0, 3, 2'b00};
    tbl[2]  = '{1'b1, 3'd0, 32'h104, 32'h000000F0, 0, 32'h0,        1'b0, 2, 2'b00};
    tbl[3]  = '{1'b0, 3'd0, 32'h104, 32'h0,        1, 32'hFFFFFFF0, 1'b0, 3, 2'b00};
    tbl[4]  = '{1'b0, 3'd4, 32'h104, 32'h0,        0, 32'h000000F0, 1'b0, 3, 2'b00};
    tbl[5]  = '{1'b1, 3'd1, 32'h108, 32'h00008001, 0, 32'h0,        1'b0, 2, 2'b01};
    tbl[6]  = '{1'b0, 3'd1, 32'h108, 32'h0,        0, 32'hFFFF8001, 1'b0, 3, 2'b00};
    tbl[7]  = '{1'b0, 3'd5, 32'h108, 32'h0,        5, 32'h00008001, 1'b0, 3, 2'b00};
    tbl[8]  = '{1'b0, 3'd3, 32'h100, 32'h0,        0, 32'h0,        1'b1, 1, 2'b00};
    tbl[9]  = '{1'b1, 3'd4, 32'h10C, 32'h55555555, 2, 32'h0,        1'b1, 1, 2'b00};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[10] = '{1'b0, 3'd1, 32'h101, 32'h0,        0, 32'h0,        1'b1, 1, 2'b00};
    tbl[11] = '{1'b0, 3'd2, 32'h102, 32'h0,        0, 32'h0,        1'b1, 1, 2'b00};
`else
    tbl[10] = '{1'b0, 3'd1, 32'h101, 32'h0,        0, 32'hFFFFADBE, 1'b0, 3, 2'b00};
    tbl[11] = '{1'b0, 3'd2, 32'h102, 32'h0,        0, 32'h00F0DEAD, 1'b0, 3, 2'b00};
`endif
    tbl[12] = '{1'b1, 3'd2, 32'h10C, 32'h12345678, 2, 32'h0,        1'b0, 2, 2'b11};
    tbl[13] = '{1'b0, 3'd4, 32'h10F, 32'h0,        0, 32'h00000012, 1'b0, 3, 2'b00};
    tbl[14] = '{1'b0, 3'd0, 32'h10E, 32'h0,        3, 32'h00000034, 1'b0, 3, 2'b00};

    for (int i = 0; i < 15; i++) begin
      apply_vec($sformatf("vec%0d", i), tbl[i]);
      if (tbl[i].we && !tbl[i].exp_err) model_store(int'(tbl[i].f3), tbl[i].addr, tbl[i].wdata);
    end

    // Reset while the read strobe is up: strobe must drop without a clock edge, no response.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_ren_high", 32'(mem_ren), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_ren_async_drop", 32'(mem_ren), 32'd0);
    chk("abort_ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_release", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_activity", {29'd0, resp_valid, mem_wen, mem_ren}, 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      rv.we    = 1'($urandom);
      rv.f3    = 3'($urandom);
      rv.addr  = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 31));
      rv.wdata = $urandom;
      rv.hold  = $urandom_range(0, 3);
      rv.exp_err   = !model_legal(rv.we, int'(rv.f3), rv.addr);
      rv.exp_lat   = rv.exp_err ? 1 : (rv.we ? 2 : 3);
      rv.exp_rdata = (rv.exp_err || rv.we) ? 32'h0 : model_load(int'(rv.f3), rv.addr);
      rv.exp_wb    = (rv.f3 == 3'd0) ? 2'b00 : (rv.f3 == 3'd1) ? 2'b01 : 2'b11;
      apply_vec($sformatf("rnd%0d", n), rv);
      if (rv.we && !rv.exp_err) model_store(int'(rv.f3), rv.addr, rv.wdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
